// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared state encoding, owner codes and defaults for the display arbiter
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_OWN_CPU = 2'b01,
        ST_OWN_DBG = 2'b10
    } disp_state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DBG  = 2'b10;

    localparam int HOLD_CYC_DEF = 50000;

    function automatic logic [1:0] owner_of(input disp_state_e s);
        case (s)
            ST_OWN_CPU: return OWN_CPU;
            ST_OWN_DBG: return OWN_DBG;
            default:    return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/disp_hold_timer.sv
// rtl/disp_hold_timer.sv - clearable saturating hold counter with done flag
module disp_hold_timer
    import disp_pkg::*;
#(
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_MAX);

endmodule

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin owner arbiter for the digital-tube display
module seg_display_arbiter
    import disp_pkg::*;
#(
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [31:0] cpu_data,
    input  logic        dbg_req,
    input  logic [31:0] dbg_data,
    output logic        cpu_gnt,
    output logic        dbg_gnt,
    output logic [31:0] show_data,
    output logic [1:0]  owner
);

    disp_state_e state_q, state_d;
    logic        last_dbg_q, last_dbg_d;
    logic [31:0] show_q, show_d;
    logic        cpu_gnt_q, dbg_gnt_q;
    logic [1:0]  owner_q;
    logic        tmr_clr, tmr_en, tmr_done;

    disp_hold_timer #(.HOLD_CYC(HOLD_CYC)) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .done  (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        last_dbg_d = last_dbg_q;
        show_d     = show_q;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // On a tie the requester that did not own last time wins
                if (cpu_req && (!dbg_req || last_dbg_q)) begin
                    state_d    = ST_OWN_CPU;
                    last_dbg_d = 1'b0;
                    show_d     = cpu_data;
                    tmr_clr    = 1'b1;
                end else if (dbg_req) begin
                    state_d    = ST_OWN_DBG;
                    last_dbg_d = 1'b1;
                    show_d     = dbg_data;
                    tmr_clr    = 1'b1;
                end
            end
            ST_OWN_CPU: begin
                tmr_en = 1'b1;
                if (cpu_req) begin
                    show_d = cpu_data;
                end else if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN_DBG: begin
                tmr_en = 1'b1;
                if (dbg_req) begin
                    show_d = dbg_data;
                end else if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_dbg_q <= 1'b1;
            show_q     <= 32'h0;
            cpu_gnt_q  <= 1'b0;
            dbg_gnt_q  <= 1'b0;
            owner_q    <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            last_dbg_q <= last_dbg_d;
            show_q     <= show_d;
            cpu_gnt_q  <= (state_d == ST_OWN_CPU);
            dbg_gnt_q  <= (state_d == ST_OWN_DBG);
            owner_q    <= owner_of(state_d);
        end
    end

    assign cpu_gnt   = cpu_gnt_q;
    assign dbg_gnt   = dbg_gnt_q;
    assign show_data = show_q;
    assign owner     = owner_q;

endmodule
